// File: rtl/cursor_pkg.sv
// cursor_pkg: shared state encoding and default geometry for the cursor stepper
package cursor_pkg;
  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_e;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int POS_W_DEF = 10;
endpackage

// File: rtl/cursor_axis.sv
// cursor_axis: one-axis step with clamped bounds, or toroidal bounds when CURSOR_WRAP_EN is defined
module cursor_axis
  import cursor_pkg::*;
#(
  parameter int RES   = H_RES_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic [1:0]       dir_i,
  input  logic [POS_W-1:0] step_i,
  output logic [POS_W-1:0] pos_o,
  output logic             changed_o
);
  localparam logic [POS_W:0] RES_L = (POS_W+1)'(RES);
  logic [POS_W:0] pos_w, step_w, sum, nxt;
  logic inc, dec;
  assign pos_w = {1'b0, pos_i};
  assign step_w = {1'b0, step_i};
  assign inc = dir_i == 2'b01;
  assign dec = dir_i == 2'b11;
  assign sum = pos_w + step_w;
  // dir encoding: 01 = +1, 11 = -1, 00 = hold
  always_comb begin
`ifdef CURSOR_WRAP_EN
    nxt = inc ? (sum >= RES_L ? sum - RES_L : sum) :
          dec ? (step_w > pos_w ? pos_w + RES_L - step_w : pos_w - step_w) : pos_w;
`else
    nxt = inc ? (sum >= RES_L ? RES_L - 1'b1 : sum) :
          dec ? (step_w > pos_w ? '0 : pos_w - step_w) : pos_w;
`endif
  end
  assign pos_o = nxt[POS_W-1:0];
  assign changed_o = nxt != pos_w;
endmodule

// File: rtl/cursor_stepper.sv
// cursor_stepper: four buttons to (x, y) cursor with tick divider, hold acceleration; CURSOR_WRAP_EN selects toroidal bounds
module cursor_stepper
  import cursor_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int X_INIT     = 360,
  parameter int Y_INIT     = 200,
  parameter int TICK_DIV   = 500000,
  parameter int ACCEL_HOLD = 32,
  parameter int FAST_STEP  = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             BTN_EAST,
  input  logic             BTN_WEST,
  input  logic             BTN_NORTH,
  input  logic             BTN_SOUTH,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             moving
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(ACCEL_HOLD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(ACCEL_HOLD);
  localparam logic [POS_W-1:0] FAST_L = POS_W'(FAST_STEP);
  localparam logic [POS_W-1:0] ONE_L = POS_W'(1);
  localparam logic [POS_W-1:0] X_INIT_L = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_INIT_L = POS_W'(Y_INIT);

  logic [3:0] s1_q, s2_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  state_e st_q, st_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d, x_nxt, y_nxt, step;
  logic moving_q, moving_d, tick, active, x_chg, y_chg;
  logic [1:0] xdir, ydir;

  // s2_q bits: [3]=east [2]=west [1]=north [0]=south; opposing presses cancel
  assign xdir = {s2_q[2] & ~s2_q[3], s2_q[3] ^ s2_q[2]};
  assign ydir = {s2_q[1] & ~s2_q[0], s2_q[1] ^ s2_q[0]};
  assign step = st_q == FAST ? FAST_L : ONE_L;

  cursor_axis #(.RES(H_RES), .POS_W(POS_W)) u_x (
    .pos_i(x_q), .dir_i(xdir), .step_i(step), .pos_o(x_nxt), .changed_o(x_chg)
  );

  cursor_axis #(.RES(V_RES), .POS_W(POS_W)) u_y (
    .pos_i(y_q), .dir_i(ydir), .step_i(step), .pos_o(y_nxt), .changed_o(y_chg)
  );

  // tick divider, hold/state advance and position update, all gated by tick
  always_comb begin
    tick = cnt_q == TICK_LAST;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    active = xdir[0] | ydir[0];
    hold_inc = hold_q == HOLD_MAX ? hold_q : hold_q + 1'b1;
    hold_d = !tick ? hold_q : active ? hold_inc : '0;
    st_d = !tick ? st_q : !active ? IDLE : hold_inc == HOLD_MAX ? FAST : SLOW;
    x_d = tick ? x_nxt : x_q;
    y_d = tick ? y_nxt : y_q;
    moving_d = tick & (x_chg | y_chg);
  end

  // synchroniser and state registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      st_q <= IDLE;
      x_q <= X_INIT_L;
      y_q <= Y_INIT_L;
      moving_q <= 1'b0;
    end else begin
      s1_q <= {BTN_EAST, BTN_WEST, BTN_NORTH, BTN_SOUTH};
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      st_q <= st_d;
      x_q <= x_d;
      y_q <= y_d;
      moving_q <= moving_d;
    end
  end

  assign x_pos = x_q;
  assign y_pos = y_q;
  assign moving = moving_q;
endmodule

// File: tb/tb_cursor_stepper.sv
// tb_cursor_stepper: table-driven check of two cursor_stepper instances plus pulse and mid-tick reset sequences
module tb_cursor_stepper;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [3:0] E = 4'b1000, W = 4'b0100, N = 4'b0010, S = 4'b0001, Z = 4'b0000;

  typedef struct {
    logic rst;
    logic [3:0] ba, bb;
    logic [15:0] ax, ay;
    logic am;
    logic [15:0] bx, by;
    logic bm;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] ba = '0, bb = '0;
  logic [9:0] ax, ay, bx, by;
  logic am, bm;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[11];

  cursor_stepper #(.TICK_DIV(4), .ACCEL_HOLD(3), .FAST_STEP(4)) u_a (
    .clk_in(clk), .rst_n(rst_n), .BTN_EAST(ba[3]), .BTN_WEST(ba[2]),
    .BTN_NORTH(ba[1]), .BTN_SOUTH(ba[0]), .x_pos(ax), .y_pos(ay), .moving(am)
  );

  cursor_stepper #(.X_INIT(2), .Y_INIT(478), .TICK_DIV(4), .ACCEL_HOLD(3), .FAST_STEP(4)) u_b (
    .clk_in(clk), .rst_n(rst_n), .BTN_EAST(bb[3]), .BTN_WEST(bb[2]),
    .BTN_NORTH(bb[1]), .BTN_SOUTH(bb[0]), .x_pos(bx), .y_pos(by), .moving(bm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ba = Z;
    bb = Z;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, E, W, 16'd361, 16'd200, 1'b1, 16'd1, 16'd478, 1'b1};
    tbl[1]  = '{1'b0, E, W, 16'd362, 16'd200, 1'b1, 16'd0, 16'd478, 1'b1};
    tbl[2]  = '{1'b0, E, W, 16'd363, 16'd200, 1'b1, WRAP ? 16'd639 : 16'd0, 16'd478, WRAP};
    tbl[3]  = '{1'b0, E, S, 16'd367, 16'd200, 1'b1, WRAP ? 16'd639 : 16'd0, WRAP ? 16'd2 : 16'd479, 1'b1};
    tbl[4]  = '{1'b0, E, S, 16'd371, 16'd200, 1'b1, WRAP ? 16'd639 : 16'd0, WRAP ? 16'd6 : 16'd479, WRAP};
    tbl[5]  = '{1'b0, Z, Z, 16'd371, 16'd200, 1'b0, WRAP ? 16'd639 : 16'd0, WRAP ? 16'd6 : 16'd479, 1'b0};
    tbl[6]  = '{1'b0, E, Z, 16'd372, 16'd200, 1'b1, WRAP ? 16'd639 : 16'd0, WRAP ? 16'd6 : 16'd479, 1'b0};
    tbl[7]  = '{1'b1, E | W | N, E | W | N | S, 16'd360, 16'd199, 1'b1, 16'd2, 16'd478, 1'b0};
    tbl[8]  = '{1'b0, E | W | N | S, N, 16'd360, 16'd199, 1'b0, 16'd2, 16'd477, 1'b1};
    tbl[9]  = '{1'b1, Z, S, 16'd360, 16'd200, 1'b0, 16'd2, 16'd479, 1'b1};
    tbl[10] = '{1'b0, Z, S, 16'd360, 16'd200, 1'b0, 16'd2, WRAP ? 16'd0 : 16'd479, WRAP};
    do_reset();
    n_vec++;
    chk("reset ax", 16'(ax), 16'd360);
    chk("reset ay", 16'(ay), 16'd200);
    chk("reset am", 16'(am), 16'd0);
    chk("reset bx", 16'(bx), 16'd2);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      ba = tbl[i].ba;
      bb = tbl[i].bb;
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      chk($sformatf("v%0d ax", i), 16'(ax), tbl[i].ax);
      chk($sformatf("v%0d ay", i), 16'(ay), tbl[i].ay);
      chk($sformatf("v%0d am", i), 16'(am), 16'(tbl[i].am));
      chk($sformatf("v%0d bx", i), 16'(bx), tbl[i].bx);
      chk($sformatf("v%0d by", i), 16'(by), tbl[i].by);
      chk($sformatf("v%0d bm", i), 16'(bm), 16'(tbl[i].bm));
    end
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ba = E;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    chk("pulse ax", 16'(ax), 16'd361);
    chk("pulse am", 16'(am), 16'd1);
    @(posedge clk);
    #1;
    chk("pulse drop am", 16'(am), 16'd0);
    chk("pulse hold ax", 16'(ax), 16'd361);
    repeat (3) @(posedge clk);
    #1;
    chk("hold t2 ax", 16'(ax), 16'd362);
    repeat (4) @(posedge clk);
    #1;
    chk("hold t3 ax", 16'(ax), 16'd363);
    repeat (4) @(posedge clk);
    #1;
    chk("fast t4 ax", 16'(ax), 16'd367);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    chk("midrst ax", 16'(ax), 16'd360);
    chk("midrst ay", 16'(ay), 16'd200);
    chk("midrst am", 16'(am), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst pre-tick ax", 16'(ax), 16'd360);
    @(posedge clk);
    #1;
    chk("postrst tick ax", 16'(ax), 16'd361);
    chk("postrst tick am", 16'(am), 16'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("postrst slow ax", 16'(ax), 16'd362);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cursor_stepper.md
# cursor_stepper

Parametrised button-driven cursor position generator: turns four directional push-buttons into an (x, y) pointer coordinate for the VGA overlay and pointer logic. Unlike the first-generation button mouse it runs on a single clock with an internal movement-tick divider, synchronises the buttons, accelerates after a sustained hold, and bounds positions exactly to the configured resolution.

## Interface
Parameters:
- H_RES, 640: horizontal resolution; x range 0..H_RES-1.
- V_RES, 480: vertical resolution; y range 0..V_RES-1.
- POS_W, 10: coordinate width; 2^POS_W ≥ max(H_RES, V_RES).
- X_INIT, 360: x reset value.
- Y_INIT, 200: y reset value.
- TICK_DIV, 500000: clk_in cycles per movement tick (≥ 2).
- ACCEL_HOLD, 32: consecutive held ticks before fast stepping.
- FAST_STEP, 4: step size in FAST; 1 < FAST_STEP < min(H_RES, V_RES).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- BTN_EAST, BTN_WEST, BTN_NORTH, BTN_SOUTH  input  1 each  asynchronous buttons, active high.
- x_pos  output  POS_W  cursor x.
- y_pos  output  POS_W  cursor y.
- moving  output  1  high for one cycle on each tick that changed x_pos or y_pos.

## Operation
- Reset (rst_n low at a clk_in edge): x_pos=X_INIT, y_pos=Y_INIT, moving=0, tick counter=0, hold counter=0, state=IDLE, synchroniser flops=0. Applies mid-tick and mid-hold; no partial move survives.
- Buttons pass a 2-flop synchroniser; only synchronised values are used.
- Tick counter counts 0..TICK_DIV-1; tick asserted in the cycle the count equals TICK_DIV-1, then wraps to 0.
- Per axis, direction = (+1 for EAST/SOUTH) + (−1 for WEST/NORTH); opposing buttons both pressed → 0 on that axis. "Active" = any axis nonzero.
- State machine, evaluated only on tick:
  - IDLE: step 0. Active → SLOW, hold=1, move by 1 this tick.
  - SLOW: step 1. Inactive → IDLE, hold=0. Active → hold+1; when hold reaches ACCEL_HOLD → FAST (fast step starts next tick).
  - FAST: step FAST_STEP. Inactive → IDLE, hold=0.
  - Hold counter saturates at ACCEL_HOLD.
- Arithmetic in POS_W+1 bits:
  - Increment: sum = pos + step; sum ≥ RES → RES-1 (clamp).
  - Decrement: step > pos → 0, else pos − step.
  - Exact: pos=1 decrementing by 1 gives 0; pos=RES-2 incrementing by 1 gives RES-1.
- Both axes update on the same tick (diagonal allowed).
- moving=1 only if a coordinate value actually changed; held against a clamped edge gives moving=0, but state/hold still advance.

## Timing
- Button edge → synchronised: 2 cycles. Synchronised → position change: at the next tick, worst case TICK_DIV cycles.
- x_pos, y_pos, moving registered; update on the clock edge ending the tick cycle; moving drops the following cycle.
- Button released between ticks is not seen; no latching of short presses.

## Configuration
- CURSOR_WRAP_EN defined: toroidal bounds; increment past RES-1 gives sum − RES, decrement below 0 gives pos + RES − step; moving is 1 on every tick with nonzero direction.
- Not defined: clamping as in Operation.

## Structure
- Shared package cursor_pkg: state enum (IDLE, SLOW, FAST), default resolution constants (640/480), POS_W default.
- One sub-module: cursor_axis, per-axis step/bound arithmetic (inputs pos, dir, step; output next pos, changed), instantiated for x with H_RES and y with V_RES.
- Tick divider, synchroniser, FSM in the top.

## Test plan
Use TICK_DIV=4, ACCEL_HOLD=3, FAST_STEP=4.
- Reset → x=360, y=200, moving=0; EAST held 1 tick → x=361, moving pulses one cycle.
- EAST held 5 ticks from 360 → 361, 362, 363, 367, 371 (FAST after 3 ticks); release 1 tick, press again → step 1.
- WEST held from x=2 → 1, 0, 0; moving=0 on clamped tick; SOUTH from y=478 → 479, 479.
- EAST+WEST+NORTH held from (360,200) → x stays 360, y=199; all four held → no change, moving=0.
- With CURSOR_WRAP_EN: x=639 EAST → 0; y=1 in FAST NORTH → 477.
- rst_n low mid-tick during FAST at x=500 → next edge x=360, state IDLE; first post-reset tick with EAST → 361.
